// File: rtl/hub_bus_pkg.sv
// Shared definitions for the cog<->hub slotted bus: size codes, slot and lock
// geometry, and the slot rotation rule used by both ends of the bus.
package hub_bus_pkg;

    localparam int NUM_SLOTS = 8;
    localparam int LOCK_ID_W = 3;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_WORD = 2'b01;
    localparam logic [1:0] SZ_LONG = 2'b10;

    // Shift the one-hot select left; an empty or top-slot select restarts at slot 0.
    function automatic logic [NUM_SLOTS-1:0] next_sel(input logic [NUM_SLOTS-1:0] sel);
        logic unused_msb;
        unused_msb = sel[NUM_SLOTS-1];
        return {sel[NUM_SLOTS-2:0], ~|sel[NUM_SLOTS-2:0]};
    endfunction

endpackage

// File: rtl/hub_slot_responder_if.sv
// Slotted bus between the cogs (master) and the hub responder (slave).
interface hub_slot_responder_if;
    import hub_bus_pkg::*;

    logic                         ena_bus;
    logic [NUM_SLOTS-1:0]         bus_sel;
    logic                         bus_r;
    logic                         bus_e;
    logic                         bus_w;
    logic [1:0]                   bus_s;
    logic [15:0]                  bus_a;
    logic [31:0]                  bus_d;
    logic [31:0]                  bus_q;
    logic                         bus_c;
    logic [NUM_SLOTS-1:0]         bus_ack;
    logic [(1 << LOCK_ID_W)-1:0]  lock_state;

    modport slave (
        output ena_bus, bus_sel, bus_q, bus_c, bus_ack, lock_state,
        input  bus_r, bus_e, bus_w, bus_s, bus_a, bus_d
    );

    modport master (
        input  ena_bus, bus_sel, bus_q, bus_c, bus_ack, lock_state,
        output bus_r, bus_e, bus_w, bus_s, bus_a, bus_d
    );

endinterface

// File: rtl/hub_ram_lanes.sv
// Hub RAM: single-port, 32-bit longs with per-byte write enables and a
// registered read (read-first on a simultaneous write).
module hub_ram_lanes #(
    parameter int LONGS_W = 13
) (
    input  logic               clk,
    input  logic [3:0]         we,
    input  logic [LONGS_W-1:0] addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata
);

    logic [31:0] mem [0:(1 << LONGS_W)-1];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
        rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/hub_slot_responder.sv
// Hub end of the slotted bus: drives slot timing, accepts the selected cog's
// request on the slot's second clock, services RAM/lock ops, answers one clock later.
module hub_slot_responder #(
    parameter int LONGS_W   = 13,
    parameter int NUM_SLOTS = 8
) (
    input  logic                 clk_cog,
    input  logic                 inp_res,
    hub_slot_responder_if.slave  bus
);
    import hub_bus_pkg::*;

    localparam int NUM_LOCKS = 1 << LOCK_ID_W;

    function automatic logic [31:0] lane_extract(input logic [31:0] w, input logic [1:0] sz,
                                                 input logic [1:0] lane);
        logic [31:0] ret;
        case (sz)
            SZ_BYTE: ret = {24'd0, w[{lane, 3'b000} +: 8]};
            SZ_WORD: ret = {16'd0, w[{lane[1], 4'b0000} +: 16]};
            SZ_LONG: ret = w;
            default: ret = w;
        endcase
        return ret;
    endfunction

    function automatic logic [3:0] lane_enables(input logic [1:0] sz, input logic [1:0] lane);
        logic [3:0] ret;
        case (sz)
            SZ_BYTE: ret = 4'b0001 << lane;
            SZ_WORD: ret = lane[1] ? 4'b1100 : 4'b0011;
            default: ret = 4'b1111;
        endcase
        return ret;
    endfunction

    function automatic logic [31:0] lane_data(input logic [31:0] d, input logic [1:0] sz);
        logic [31:0] ret;
        case (sz)
            SZ_BYTE: ret = {4{d[7:0]}};
            SZ_WORD: ret = {2{d[15:0]}};
            default: ret = d;
        endcase
        return ret;
    endfunction

    logic                  ena_q, ena_d;
    logic [NUM_SLOTS-1:0]  sel_q, sel_d;
    logic [NUM_LOCKS-1:0]  lock_q, lock_d;
    logic                  vld_p1_q, vld_p1_d;
    logic [NUM_SLOTS-1:0]  ack_p1_q, ack_p1_d;
    logic                  lock_op_p1_q, lock_op_p1_d;
    logic                  mem_rd_p1_q, mem_rd_p1_d;
    logic [1:0]            size_p1_q, size_p1_d;
    logic [1:0]            lane_p1_q, lane_p1_d;
    logic                  c_p1_q, c_p1_d;
    logic [LOCK_ID_W-1:0]  lid_p1_q, lid_p1_d;

    logic                  accept;
    logic [LOCK_ID_W-1:0]  lid;
    logic [3:0]            ram_we;
    logic [31:0]           ram_rdata;
    logic                  rsp_live;
    logic [31:0]           bus_q_c;
    logic                  unused_addr;

    assign lid         = bus.bus_a[LOCK_ID_W-1:0];
    assign unused_addr = ^bus.bus_a[15:LONGS_W+2];
    assign accept      = ena_q & (|sel_q) & bus.bus_r & ~inp_res;
    assign ram_we      = (accept & ~bus.bus_e & bus.bus_w)
                         ? lane_enables(bus.bus_s, bus.bus_a[1:0]) : 4'b0000;

    hub_ram_lanes #(.LONGS_W(LONGS_W)) u_ram (
        .clk   (clk_cog),
        .we    (ram_we),
        .addr  (bus.bus_a[LONGS_W+1:2]),
        .wdata (lane_data(bus.bus_d, bus.bus_s)),
        .rdata (ram_rdata)
    );

    always_comb begin
        ena_d        = ~ena_q;
        sel_d        = ena_q ? next_sel(sel_q) : sel_q;
        lock_d       = lock_q;
        if (accept && bus.bus_e) begin
            lock_d[lid] = bus.bus_w;
        end
        vld_p1_d     = accept;
        ack_p1_d     = accept ? sel_q : '0;
        lock_op_p1_d = bus.bus_e;
        mem_rd_p1_d  = ~bus.bus_w;
        size_p1_d    = bus.bus_s;
        lane_p1_d    = bus.bus_a[1:0];
        c_p1_d       = lock_q[lid];
        lid_p1_d     = lid;
    end

    // Sample edge -> response stage (p1)
    always_ff @(posedge clk_cog) begin
        if (inp_res) begin
            ena_q    <= 1'b0;
            sel_q    <= '0;
            lock_q   <= '0;
            vld_p1_q <= 1'b0;
            ack_p1_q <= '0;
        end else begin
            ena_q    <= ena_d;
            sel_q    <= sel_d;
            lock_q   <= lock_d;
            vld_p1_q <= vld_p1_d;
            ack_p1_q <= ack_p1_d;
        end
        lock_op_p1_q <= lock_op_p1_d;
        mem_rd_p1_q  <= mem_rd_p1_d;
        size_p1_q    <= size_p1_d;
        lane_p1_q    <= lane_p1_d;
        c_p1_q       <= c_p1_d;
        lid_p1_q     <= lid_p1_d;
    end

    // Reset raised during the response cycle withdraws the answer immediately.
    assign rsp_live = vld_p1_q & ~inp_res;

    always_comb begin
        bus_q_c = '0;
        if (rsp_live) begin
            if (lock_op_p1_q) begin
                bus_q_c = {{(32-LOCK_ID_W){1'b0}}, lid_p1_q};
            end else if (mem_rd_p1_q) begin
                bus_q_c = lane_extract(ram_rdata, size_p1_q, lane_p1_q);
            end
        end
    end

    assign bus.ena_bus    = ena_q;
    assign bus.bus_sel    = sel_q;
    assign bus.bus_ack    = rsp_live ? ack_p1_q : '0;
    assign bus.bus_q      = bus_q_c;
    assign bus.bus_c      = rsp_live & lock_op_p1_q & c_p1_q;
    assign bus.lock_state = lock_q;

endmodule

// File: tb/tb_hub_slot_responder.sv
// Bench for hub_slot_responder: vector table of slot requests plus reset and
// ignored-request sequences, responses checked through a scoreboard queue.
module tb_hub_slot_responder;
    import hub_bus_pkg::*;

    typedef struct {
        int          slot;
        logic        e;
        logic        w;
        logic [1:0]  s;
        logic [15:0] a;
        logic [31:0] d;
        logic [31:0] q;
        logic        c;
        logic [7:0]  lk;
    } vec_t;

    typedef struct {
        logic [7:0]  ack;
        logic [31:0] q;
        logic        c;
    } rsp_t;

    logic clk = 1'b0;
    logic inp_res;
    logic mon_en = 1'b0;
    int   checks = 0;
    int   errors = 0;
    rsp_t sb[$];
    vec_t tbl[18];

    hub_slot_responder_if ifc ();

    hub_slot_responder #(.LONGS_W(13), .NUM_SLOTS(8)) dut (
        .clk_cog (clk),
        .inp_res (inp_res),
        .bus     (ifc.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        rsp_t r;
        if (mon_en) begin
            if (ifc.bus_ack !== 8'h00) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ack", {24'd0, ifc.bus_ack}, 32'd0);
                end else begin
                    r = sb.pop_front();
                    chk("ack", {24'd0, ifc.bus_ack}, {24'd0, r.ack});
                    chk("q", ifc.bus_q, r.q);
                    chk("c", {31'd0, ifc.bus_c}, {31'd0, r.c});
                end
            end else begin
                chk("idle_q", ifc.bus_q, 32'd0);
                chk("idle_c", {31'd0, ifc.bus_c}, 32'd0);
            end
        end
    end

    task automatic drive(input logic r, input logic e, input logic w, input logic [1:0] s,
                         input logic [15:0] a, input logic [31:0] d);
        ifc.bus_r = r;
        ifc.bus_e = e;
        ifc.bus_w = w;
        ifc.bus_s = s;
        ifc.bus_a = a;
        ifc.bus_d = d;
    endtask

    task automatic wait_slot(input int slot);
        logic [7:0] tgt;
        int n;
        tgt = 8'h01 << slot;
        n = 0;
        while (!(ifc.ena_bus === 1'b1 && ifc.bus_sel === tgt) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("slot_timeout", {24'd0, ifc.bus_sel}, {24'd0, tgt});
    endtask

    task automatic issue(input vec_t v);
        wait_slot(v.slot);
        drive(1'b1, v.e, v.w, v.s, v.a, v.d);
        sb.push_back('{8'h01 << v.slot, v.q, v.c});
        @(negedge clk);
        ifc.bus_r = 1'b0;
        #1;
        chk("rsp_seen", sb.size(), 32'd0);
        chk("lock_state", {24'd0, ifc.lock_state}, {24'd0, v.lk});
    endtask

    // Called at a negedge with reset held; releases it and follows the rotation.
    // With poke set, a long write is offered only on edges that must ignore it.
    task automatic rotation(input int n, input logic poke);
        logic       exp_ena;
        logic [7:0] exp_sel;
        inp_res = 1'b0;
        drive(poke, 1'b0, 1'b1, SZ_LONG, 16'h0100, 32'h12345678);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            exp_ena = (k % 2 == 0);
            exp_sel = (k == 0) ? 8'h00 : 8'h01 << (((k - 1) / 2) % 8);
            chk("rot_ena", {31'd0, ifc.ena_bus}, {31'd0, exp_ena});
            chk("rot_sel", {24'd0, ifc.bus_sel}, {24'd0, exp_sel});
            ifc.bus_r = poke & ((k == 0) | ~exp_ena);
        end
        ifc.bus_r = 1'b0;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_ena", {31'd0, ifc.ena_bus}, 32'd0);
        chk("rst_sel", {24'd0, ifc.bus_sel}, 32'd0);
        chk("rst_ack", {24'd0, ifc.bus_ack}, 32'd0);
        chk("rst_q", ifc.bus_q, 32'd0);
        chk("rst_c", {31'd0, ifc.bus_c}, 32'd0);
        chk("rst_lock", {24'd0, ifc.lock_state}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0]  = '{3, 1'b0, 1'b1, SZ_LONG, 16'h0100, 32'hDEADBEEF, 32'h00000000, 1'b0, 8'h00};
        tbl[1]  = '{5, 1'b0, 1'b0, SZ_LONG, 16'h0100, 32'h0,        32'hDEADBEEF, 1'b0, 8'h00};
        tbl[2]  = '{6, 1'b0, 1'b1, SZ_BYTE, 16'h0102, 32'hFFFFFF5A, 32'h00000000, 1'b0, 8'h00};
        tbl[3]  = '{7, 1'b0, 1'b0, SZ_LONG, 16'h0100, 32'h0,        32'hDE5ABEEF, 1'b0, 8'h00};
        tbl[4]  = '{0, 1'b0, 1'b0, SZ_WORD, 16'h0102, 32'h0,        32'h0000DE5A, 1'b0, 8'h00};
        tbl[5]  = '{1, 1'b0, 1'b0, SZ_BYTE, 16'h0103, 32'h0,        32'h000000DE, 1'b0, 8'h00};
        tbl[6]  = '{2, 1'b1, 1'b1, SZ_LONG, 16'h0006, 32'h0,        32'h00000006, 1'b0, 8'h40};
        tbl[7]  = '{3, 1'b1, 1'b1, SZ_LONG, 16'h0006, 32'h0,        32'h00000006, 1'b1, 8'h40};
        tbl[8]  = '{4, 1'b1, 1'b0, SZ_LONG, 16'h0006, 32'h0,        32'h00000006, 1'b1, 8'h00};
        tbl[9]  = '{5, 1'b0, 1'b1, SZ_WORD, 16'h0101, 32'hABCD1234, 32'h00000000, 1'b0, 8'h00};
        tbl[10] = '{6, 1'b0, 1'b0, SZ_LONG, 16'h0100, 32'h0,        32'hDE5A1234, 1'b0, 8'h00};
        tbl[11] = '{7, 1'b0, 1'b0, SZ_LONG, 16'h8100, 32'h0,        32'hDE5A1234, 1'b0, 8'h00};
        tbl[12] = '{0, 1'b0, 1'b0, 2'b11,   16'h0101, 32'h0,        32'hDE5A1234, 1'b0, 8'h00};
        tbl[13] = '{1, 1'b1, 1'b1, SZ_BYTE, 16'hFFFA, 32'h0,        32'h00000002, 1'b0, 8'h04};
        tbl[14] = '{2, 1'b0, 1'b0, SZ_BYTE, 16'h0100, 32'h0,        32'h00000034, 1'b0, 8'h04};
        tbl[15] = '{3, 1'b0, 1'b1, SZ_LONG, 16'h0104, 32'h0BADF00D, 32'h00000000, 1'b0, 8'h04};
        tbl[16] = '{4, 1'b0, 1'b0, SZ_LONG, 16'h0104, 32'h0,        32'h0BADF00D, 1'b0, 8'h04};
        tbl[17] = '{5, 1'b0, 1'b0, SZ_BYTE, 16'h0101, 32'h0,        32'h00000012, 1'b0, 8'h04};

        inp_res = 1'b1;
        drive(1'b0, 1'b0, 1'b0, SZ_BYTE, 16'h0000, 32'h0);
        repeat (2) @(negedge clk);
        chk_reset_outputs();
        mon_en = 1'b1;

        rotation(20, 1'b1);

        for (int i = 0; i < 18; i++) begin
            issue(tbl[i]);
        end

        // Write offered only on ena_bus=0 edges: must never land.
        for (int k = 0; k < 16; k++) begin
            drive(~ifc.ena_bus, 1'b0, 1'b1, SZ_LONG, 16'h0100, 32'h12345678);
            @(negedge clk);
        end
        ifc.bus_r = 1'b0;
        issue('{6, 1'b0, 1'b0, SZ_LONG, 16'h0100, 32'h0, 32'hDE5A1234, 1'b0, 8'h04});

        // Read taken in slot 2, reset raised before its response.
        wait_slot(2);
        drive(1'b1, 1'b0, 1'b0, SZ_LONG, 16'h0104, 32'h0);
        @(posedge clk);
        #1;
        inp_res   = 1'b1;
        ifc.bus_r = 1'b0;
        @(negedge clk);
        chk("aborted_ack", {24'd0, ifc.bus_ack}, 32'd0);
        chk("aborted_q", ifc.bus_q, 32'd0);
        @(negedge clk);
        chk_reset_outputs();

        rotation(8, 1'b1);
        issue('{5, 1'b0, 1'b0, SZ_LONG, 16'h0100, 32'h0, 32'hDE5A1234, 1'b0, 8'h00});
        issue('{6, 1'b0, 1'b0, SZ_LONG, 16'h0104, 32'h0, 32'h0BADF00D, 1'b0, 8'h00});

        repeat (4) @(negedge clk);
        #1;
        chk("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
